// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command byte transmitter.
// Drives PS2 clock/data open-drain via *_drive_low; optional PS2_TX_TIMEOUT_EN.
//
// Ports:
//   clock, resetn          system clock, async active-low reset
//   tx_data, tx_start      byte to send and 1-cycle request
//   tx_busy                transfer in progress
//   tx_done, tx_err        1-cycle result pulses
//   ps2c_in, ps2d_in       raw PS2 clock/data pin levels
//   ps2c_drive_low         1 = pull PS2 clock low
//   ps2d_drive_low         1 = pull PS2 data low
//
// Macro PS2_TX_TIMEOUT_EN: when defined, SEND/ACK/RELEASE abort
// after TIMEOUT_CYCLES clocks counted from clock release.

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 50,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_drive_low,
  output logic       ps2d_drive_low
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  localparam int M1 =
    (INHIBIT_CYCLES > SETUP_CYCLES) ?
    INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int MAXC =
    (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
  localparam int TW = $clog2(MAXC + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic          c_meta, c_sync;
  logic          d_meta, d_sync;
  logic          c_filt, d_filt;
  logic [FW-1:0] c_cnt, d_cnt;
  logic          c_prev;
  logic          fall;

  logic [2:0]    state;
  logic [TW-1:0] tmr;
  logic [3:0]    n;
  logic [7:0]    data_q;
  logic          par_q;
  logic          ack_q;
  logic          nbit;
  logic          to_hit;

  // Synchronisers idle high, matching released lines
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      c_meta <= 1'b1;
      c_sync <= 1'b1;
      d_meta <= 1'b1;
      d_sync <= 1'b1;
    end else begin
      c_meta <= ps2c_in;
      c_sync <= c_meta;
      d_meta <= ps2d_in;
      d_sync <= d_meta;
    end
  end

  // Filtered level flips on the FILTER_LEN-th
  // consecutive differing sample
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      c_filt <= 1'b1;
      c_cnt  <= '0;
    end else if (c_sync == c_filt) begin
      c_cnt  <= '0;
    end else if (c_cnt == FW'(FILTER_LEN - 1)) begin
      c_filt <= c_sync;
      c_cnt  <= '0;
    end else begin
      c_cnt  <= c_cnt + FW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      d_filt <= 1'b1;
      d_cnt  <= '0;
    end else if (d_sync == d_filt) begin
      d_cnt  <= '0;
    end else if (d_cnt == FW'(FILTER_LEN - 1)) begin
      d_filt <= d_sync;
      d_cnt  <= '0;
    end else begin
      d_cnt  <= d_cnt + FW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) c_prev <= 1'b1;
    else         c_prev <= c_filt;
  end

  assign fall = c_prev & ~c_filt;

  // Frame bit n: data LSB first, parity, stop
  always_comb begin
    nbit = 1'b1;
    if (n < 4'd8)
      nbit = data_q[n[2:0]];
    else if (n == 4'd8)
      nbit = par_q;
  end

`ifdef PS2_TX_TIMEOUT_EN
  assign to_hit = (tmr == TW'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= S_IDLE;
      tmr            <= '0;
      n              <= '0;
      data_q         <= '0;
      par_q          <= 1'b0;
      ack_q          <= 1'b0;
      tx_busy        <= 1'b0;
      tx_done        <= 1'b0;
      tx_err         <= 1'b0;
      ps2c_drive_low <= 1'b0;
      ps2d_drive_low <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      // busy covers the result pulse cycle, then drops
      if (tx_done || tx_err)
        tx_busy <= 1'b0;

      unique case (state)
        S_IDLE: begin
          ps2c_drive_low <= 1'b0;
          ps2d_drive_low <= 1'b0;
          if (tx_start && !tx_busy) begin
            data_q         <= tx_data;
            par_q          <= ~^tx_data;
            tx_busy        <= 1'b1;
            ps2c_drive_low <= 1'b1;
            tmr            <= '0;
            state          <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (tmr == TW'(INHIBIT_CYCLES - 1)) begin
            tmr            <= '0;
            ps2d_drive_low <= 1'b1;
            state          <= S_REQ;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end

        S_REQ: begin
          if (tmr == TW'(SETUP_CYCLES - 1)) begin
            tmr            <= '0;
            n              <= '0;
            ps2c_drive_low <= 1'b0;
            state          <= S_SEND;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end

        S_SEND, S_ACK, S_RELEASE: begin
          if (to_hit) begin
            ps2c_drive_low <= 1'b0;
            ps2d_drive_low <= 1'b0;
            tx_err         <= 1'b1;
            state          <= S_IDLE;
          end else begin
`ifdef PS2_TX_TIMEOUT_EN
            tmr <= tmr + TW'(1);
`endif
            if (state == S_SEND) begin
              if (fall) begin
                // 11th fall: stop already out,
                // device ack is on data now
                if (n == 4'd10) begin
                  ack_q <= ~d_filt;
                  state <= S_ACK;
                end else begin
                  ps2d_drive_low <= ~nbit;
                  n <= n + 4'd1;
                end
              end
            end else if (state == S_ACK) begin
              if (ack_q) begin
                state <= S_RELEASE;
              end else begin
                tx_err <= 1'b1;
                state  <= S_IDLE;
              end
            end else begin
              if (c_filt && d_filt) begin
                tx_done <= 1'b1;
                state   <= S_IDLE;
              end
            end
          end
        end

        default: begin
          ps2c_drive_low <= 1'b0;
          ps2d_drive_low <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with a PS/2 device model.
// Scoreboard holds expected frames/acks; tasks compare inline.

module tb_ps2_host_tx;

  localparam int INH = 5000;
  localparam int SET = 50;
  localparam int FLT = 8;
  localparam int TO  = 3000;
  localparam int H   = 40;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_err;
  logic       ps2c_in, ps2d_in;
  logic       c_low, d_low;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       glitch = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  logic prev_pulse = 1'b0;
  logic pulse_busy = 1'b0;
  logic post_busy = 1'b1;

  logic [9:0] exp_frame_q[$];
  logic       exp_ack_q[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .FILTER_LEN    (FLT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock         (clk),
    .resetn        (resetn),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_err        (tx_err),
    .ps2c_in       (ps2c_in),
    .ps2d_in       (ps2d_in),
    .ps2c_drive_low(c_low),
    .ps2d_drive_low(d_low)
  );

  // Open-drain wired-AND with pull-ups
  assign ps2c_in = ~(c_low | dev_clk_low | glitch);
  assign ps2d_in = ~(d_low | dev_dat_low);

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) err_cnt <= err_cnt + 1;
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
    if (tx_done || tx_err) pulse_busy <= tx_busy;
    if (prev_pulse) post_busy <= tx_busy;
    prev_pulse <= tx_done | tx_err;
  end

  task automatic wait_cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic start(input logic [7:0] b, input bit push,
                       input bit ack);
    tx_data  = b;
    tx_start = 1'b1;
    wait_cyc(1);
    tx_start = 1'b0;
    if (push) begin
      exp_frame_q.push_back({1'b1, ~^b, b});
      exp_ack_q.push_back(ack);
    end
  endtask

  task automatic wait_release(output int inh, output int setup,
                              output int rel, output bit ok);
    inh = 0; setup = 0; rel = 0; ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (!c_low) begin
        rel = cyc;
        ok = 1'b1;
        break;
      end
      if (!d_low) inh++;
      else setup++;
      wait_cyc(1);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL release_wait: clock never released");
    end
  endtask

  // Device: 10 clocked bits sampled on rise, then the 11th
  // clock with optional ack pull; stop_at aborts mid-frame
  task automatic dev_frame(input bit do_ack, input bit glt,
                           input int stop_at,
                           output logic [9:0] cap);
    cap = '0;
    wait_cyc(H);
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      if (i == stop_at) begin
        wait_cyc(H / 2);
        return;
      end
      wait_cyc(H);
      dev_clk_low = 1'b0;
      wait_cyc(1);
      cap[i] = ps2d_in;
      if (glt && i == 4) begin
        wait_cyc(10);
        glitch = 1'b1;
        wait_cyc(FLT / 2);
        glitch = 1'b0;
        wait_cyc(H - 11 - FLT / 2);
      end else begin
        wait_cyc(H - 1);
      end
    end
    wait_cyc(H / 2);
    if (do_ack) dev_dat_low = 1'b1;
    wait_cyc(H / 2);
    dev_clk_low = 1'b1;
    wait_cyc(H);
    dev_clk_low = 1'b0;
    wait_cyc(H / 2);
    dev_dat_low = 1'b0;
  endtask

  task automatic run_frame(input string nm, input bit glt);
    logic [9:0] cap;
    logic [9:0] ef;
    logic       ea;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    ea = exp_ack_q[0];
    dev_frame(ea, glt, -1, cap);
    wait_cyc(60);
    ef = exp_frame_q.pop_front();
    ea = exp_ack_q.pop_front();
    total++;
    if (cap !== ef) begin
      bad++;
      $display("FAIL %s frame: got %b want %b", nm, cap, ef);
    end
    total++;
    if ((done_cnt - d0) !== (ea ? 1 : 0)) begin
      bad++;
      $display("FAIL %s done_count: got %0d want %0d",
               nm, done_cnt - d0, ea ? 1 : 0);
    end
    total++;
    if ((err_cnt - e0) !== (ea ? 0 : 1)) begin
      bad++;
      $display("FAIL %s err_count: got %0d want %0d",
               nm, err_cnt - e0, ea ? 0 : 1);
    end
    total++;
    if ({tx_busy, c_low, d_low} !== 3'b000) begin
      bad++;
      $display("FAIL %s idle_lines: got %b want 000",
               nm, {tx_busy, c_low, d_low});
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    wait_cyc(3);
    total++;
    if ({tx_busy, tx_done, tx_err, c_low, d_low} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 00000",
               {tx_busy, tx_done, tx_err, c_low, d_low});
    end
    resetn = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_basic();
    int inh, setup, rel;
    bit ok;
    start(8'hED, 1'b1, 1'b1);
    total++;
    if (tx_busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_start: got %b want 1", tx_busy);
    end
    wait_release(inh, setup, rel, ok);
    total++;
    if (inh !== INH) begin
      bad++;
      $display("FAIL inhibit_len: got %0d want %0d", inh, INH);
    end
    total++;
    if (setup !== SET) begin
      bad++;
      $display("FAIL setup_len: got %0d want %0d", setup, SET);
    end
    total++;
    if (exp_frame_q[0] !== 10'b11_1110_1101) begin
      bad++;
      $display("FAIL ed_expect: got %b want 1111101101",
               exp_frame_q[0]);
    end
    run_frame("ed", 1'b0);
    total++;
    if ({pulse_busy, post_busy} !== 2'b10) begin
      bad++;
      $display("FAIL busy_edges: got %b want 10",
               {pulse_busy, post_busy});
    end
  endtask

  task automatic test_parity();
    logic [7:0] bytes[3] = '{8'h00, 8'hFF, 8'h01};
    logic       pars[3]  = '{1'b1, 1'b1, 1'b0};
    int inh, setup, rel;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      start(bytes[i], 1'b1, 1'b1);
      total++;
      if (exp_frame_q[0][8] !== pars[i]) begin
        bad++;
        $display("FAIL parity_%0d: got %b want %b",
                 i, exp_frame_q[0][8], pars[i]);
      end
      wait_release(inh, setup, rel, ok);
      run_frame("parity", 1'b0);
    end
  endtask

  task automatic test_no_ack();
    int inh, setup, rel;
    bit ok;
    start(8'hF4, 1'b1, 1'b0);
    wait_release(inh, setup, rel, ok);
    run_frame("no_ack", 1'b0);
  endtask

  task automatic test_timeout();
    int inh, setup, rel, e0, hit;
    bit ok;
    e0 = err_cnt;
    start(8'h12, 1'b0, 1'b0);
    wait_release(inh, setup, rel, ok);
`ifdef PS2_TX_TIMEOUT_EN
    hit = -1;
    for (int i = 0; i < TO + 200; i++) begin
      if (tx_err) begin
        hit = cyc - rel;
        break;
      end
      wait_cyc(1);
    end
    total++;
    if (hit !== TO) begin
      bad++;
      $display("FAIL timeout_delay: got %0d want %0d", hit, TO);
    end
    wait_cyc(2);
    total++;
    if ({tx_busy, c_low, d_low} !== 3'b000) begin
      bad++;
      $display("FAIL timeout_idle: got %b want 000",
               {tx_busy, c_low, d_low});
    end
`else
    hit = 0;
    wait_cyc(TO + 200);
    total++;
    if (tx_busy !== 1'b1 || err_cnt !== e0) begin
      bad++;
      $display("FAIL no_timeout: busy %b errs %0d want 1 0",
               tx_busy, err_cnt - e0);
    end
`endif
    resetn = 1'b0;
    wait_cyc(2);
    resetn = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_reset_mid();
    logic [9:0] cap;
    int inh, setup, rel;
    bit ok;
    start(8'h86, 1'b0, 1'b0);
    wait_release(inh, setup, rel, ok);
    dev_frame(1'b0, 1'b0, 4, cap);
    total++;
    if (d_low !== 1'b1) begin
      bad++;
      $display("FAIL bit4_drive: got %b want 1", d_low);
    end
    resetn = 1'b0;
    #1;
    total++;
    if ({c_low, d_low, tx_busy} !== 3'b000) begin
      bad++;
      $display("FAIL reset_mid: got %b want 000",
               {c_low, d_low, tx_busy});
    end
    dev_clk_low = 1'b0;
    wait_cyc(3);
    resetn = 1'b1;
    wait_cyc(20);
    start(8'h5A, 1'b1, 1'b1);
    wait_release(inh, setup, rel, ok);
    run_frame("after_reset", 1'b0);
  endtask

  task automatic test_busy_ignore();
    int inh, setup, rel;
    bit ok;
    start(8'h3C, 1'b1, 1'b1);
    wait_cyc(3);
    tx_data  = 8'hAA;
    tx_start = 1'b1;
    wait_cyc(1);
    tx_start = 1'b0;
    wait_release(inh, setup, rel, ok);
    run_frame("busy_glitch", 1'b1);
    wait_cyc(300);
    total++;
    if ({tx_busy, c_low} !== 2'b00) begin
      bad++;
      $display("FAIL not_queued: got %b want 00", {tx_busy, c_low});
    end
    total++;
    if (both_cnt !== 0) begin
      bad++;
      $display("FAIL done_err_overlap: got %0d want 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_no_ack();
    test_timeout();
    test_reset_mid();
    test_busy_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
